// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high lines stay quiet through reset.
module sync_2ff #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_async_rx.sv
// 8N1 UART receiver: mid-bit sampling from a single cycle counter.
// A byte is delivered with a one-cycle strobe only when its stop bit reads high.
module uart_async_rx #(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD          = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic       RxD_waiting_data,
  output logic [7:0] RxD_data
);

  localparam int unsigned BIT_CYCLES  = (CLK_FREQUENCY + BAUD / 2) / BAUD;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CntW        = $clog2(BIT_CYCLES + 1);

  // Counter values seen on the sampling edge (counter is cleared on the previous sample edge).
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_CYCLES - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            ready_q;
  logic            waiting_q;
  logic            rx_s;

  sync_2ff #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (RxD),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      waiting_q <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            cnt_q     <= '0;
            state_q   <= StStart;
            waiting_q <= 1'b0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (rx_s) begin
              state_q   <= StIdle;
              waiting_q <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q    <= shift_q;
              ready_q   <= 1'b1;
              state_q   <= StIdle;
              waiting_q <= 1'b1;
            end else begin
              state_q <= StWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitHigh: begin
          if (rx_s) begin
            state_q   <= StIdle;
            waiting_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          waiting_q <= 1'b1;
        end
      endcase
    end
  end

  assign RxD_data_ready   = ready_q;
  assign RxD_waiting_data = waiting_q;
  assign RxD_data         = data_q;

endmodule

// File: tb/tb_uart_async_rx.sv
// Directed and random 8N1 frames against a byte-level reference model.
module tb_uart_async_rx;

  localparam int unsigned ClkFreq = 1600;
  localparam int unsigned Baud    = 100;
  localparam int unsigned BitCyc  = 16;
  localparam int unsigned HalfCyc = 8;
  localparam int unsigned Latency = 2 + 1 + HalfCyc + 9 * BitCyc;

  logic       clk;
  logic       rst;
  logic       RxD;
  logic       RxD_data_ready;
  logic       RxD_waiting_data;
  logic [7:0] RxD_data;

  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned strobes;
  int unsigned wide;
  int unsigned last_strobe_cyc;
  int unsigned prev_strobe_cyc;
  int unsigned fall_cyc;
  logic        prev_rdy;
  logic [7:0]  exp_data;
  int unsigned exp_strobes;

  uart_async_rx #(
    .CLK_FREQUENCY(ClkFreq),
    .BAUD         (Baud)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .RxD             (RxD),
    .RxD_data_ready  (RxD_data_ready),
    .RxD_waiting_data(RxD_waiting_data),
    .RxD_data        (RxD_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    strobes = 0;
    wide = 0;
    prev_rdy = 1'b0;
    last_strobe_cyc = 0;
    prev_strobe_cyc = 0;
  end

  always @(negedge clk) begin
    if (RxD_data_ready === 1'b1) begin
      strobes = strobes + 1;
      if (prev_rdy) wide = wide + 1;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
    end
    prev_rdy = (RxD_data_ready === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  // Reference model: a frame delivers its byte iff its stop bit is 1.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    fall_cyc = cyc;
    repeat (BitCyc) tick();
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BitCyc / 2) tick();
      if (i == 4) check("waiting_mid_frame", 32'(RxD_waiting_data), 32'd0);
      repeat (BitCyc / 2) tick();
    end
    RxD = stop;
    repeat (BitCyc) tick();
    if (stop) begin
      exp_data = b;
      exp_strobes++;
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
    check({tag, "_data"}, 32'(RxD_data), 32'(exp_data));
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int unsigned d;
    n_checks = 0;
    n_pass = 0;
    exp_data = 8'h00;
    exp_strobes = 0;
    rst = 1'b1;
    RxD = 1'b1;
    repeat (3) tick();
    check("reset_ready", 32'(RxD_data_ready), 32'd0);
    check("reset_data", 32'(RxD_data), 32'd0);
    check("reset_waiting", 32'(RxD_waiting_data), 32'd1);
    rst = 1'b0;
    repeat (5) tick();

    // Single byte with latency check
    send_frame(8'h61, 1'b1);
    check_rx("single");
    d = last_strobe_cyc - fall_cyc;
    check("single_latency", 32'(d >= Latency - 1 && d <= Latency + 1), 32'd1);
    repeat (10) tick();
    check("single_waiting_after", 32'(RxD_waiting_data), 32'd1);

    // Back-to-back, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    check_rx("b2b");
    d = last_strobe_cyc - prev_strobe_cyc;
    check("b2b_spacing", 32'(d >= 10 * BitCyc - 1 && d <= 10 * BitCyc + 1), 32'd1);
    repeat (10) tick();

    // False start
    RxD = 1'b0;
    repeat (4) tick();
    RxD = 1'b1;
    repeat (20) tick();
    check("false_start_waiting", 32'(RxD_waiting_data), 32'd1);
    check_rx("false_start");
    send_frame(8'hA5, 1'b1);
    check_rx("after_false_start");
    repeat (10) tick();

    // Framing error then a line held low
    send_frame(8'h3C, 1'b0);
    repeat (20) tick();
    check("frame_err_waiting_low", 32'(RxD_waiting_data), 32'd0);
    repeat (20) tick();
    RxD = 1'b1;
    repeat (20) tick();
    check("frame_err_waiting", 32'(RxD_waiting_data), 32'd1);
    check_rx("frame_err");
    send_frame(8'h5A, 1'b1);
    check_rx("after_frame_err");
    repeat (10) tick();

    // Random frames, occasional bad stop bit
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      check_rx("random");
      if (!stop) begin
        RxD = 1'b1;
        repeat (20) tick();
      end else begin
        repeat ($urandom_range(0, 10)) tick();
      end
    end
    repeat (10) tick();

    // Reset during data bit 4 of 0x81
    b = 8'h81;
    RxD = 1'b0;
    repeat (BitCyc) tick();
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      repeat (BitCyc) tick();
    end
    RxD = b[4];
    repeat (BitCyc / 2) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    RxD = 1'b1;
    exp_data = 8'h00;
    repeat (3 * BitCyc) tick();
    check_rx("reset_mid_frame");
    check("reset_mid_waiting", 32'(RxD_waiting_data), 32'd1);
    send_frame(8'h7E, 1'b1);
    check_rx("after_reset");
    repeat (10) tick();

    check("strobe_width", 32'(wide), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
